// File: rtl/audio_dac_if.sv
// Sample/control bundle between the demodulator side and the audio DAC stage.
// The master drives samples and enables; the slave returns filtered audio and the 1-bit stream.
interface audio_dac_if;
    logic               en_a;
    logic signed [15:0] demodulated;
    logic               en_sd;
    logic               deemph_en;
    logic               mute;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               dac;
    logic               dac_n;

    modport master (
        output en_a, demodulated, en_sd, deemph_en, mute,
        input  sample_out, sample_valid, dac, dac_n
    );

    modport slave (
        input  en_a, demodulated, en_sd, deemph_en, mute,
        output sample_out, sample_valid, dac, dac_n
    );
endinterface

// File: rtl/audio_dac.sv
// Audio output stage: 3-stage first-order de-emphasis IIR followed by a
// second-order CIFB sigma-delta modulator producing a 1-bit DAC stream.
module audio_dac #(
    parameter int A     = 11168,
    parameter int W_INT = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    audio_dac_if.slave  bus
);

    localparam logic signed [16:0] COEF   = 17'(A);
    localparam int                 LIM_I  = 1 << (W_INT - 2);
    localparam int                 FB_I   = 32767;
    localparam logic signed [W_INT:0] LIM_P = LIM_I[W_INT:0];
    localparam logic signed [W_INT:0] LIM_N = -LIM_P;
    localparam logic signed [W_INT:0] FB_P  = FB_I[W_INT:0];
    localparam logic signed [W_INT:0] FB_N  = -FB_P;

    // ---------------- de-emphasis pipeline ----------------
    logic signed [15:0] r_x, r_y, r_so;
    logic signed [32:0] r_p;
    logic [2:0]         r_vld_pipe;
    logic signed [16:0] w_d;
    logic signed [33:0] w_sum;
    logic signed [15:0] w_y_sat;

    assign w_d   = {r_x[15], r_x} - {r_y[15], r_y};
    assign w_sum = 34'(r_y) + 34'(r_p >>> 15);

    always_comb begin
        w_y_sat = w_sum[15:0];
        if (w_sum > 34'sd32767)
            w_y_sat = 16'sh7fff;
        else if (w_sum < -34'sd32768)
            w_y_sat = 16'sh8000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x        <= '0;
            r_p        <= '0;
            r_y        <= '0;
            r_so       <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1:0], bus.en_a};
            if (bus.en_a)
                r_x <= bus.demodulated;
            if (r_vld_pipe[0])
                r_p <= 33'(w_d) * 33'(COEF);
            // Bypass still loads y with x so re-enabling the filter starts from the current level.
            if (r_vld_pipe[1]) begin
                r_y  <= bus.deemph_en ? w_y_sat : r_x;
                r_so <= bus.deemph_en ? w_y_sat : r_x;
            end
        end
    end

    assign bus.sample_out   = r_so;
    assign bus.sample_valid = r_vld_pipe[2];

    // ---------------- sigma-delta modulator ----------------
    logic signed [W_INT-1:0] r_i1, r_i2;
    logic                    r_dac, r_dac_n;
    logic signed [W_INT:0]   w_u, w_fb, w_i1_sum, w_i2_sum;
    logic signed [W_INT-1:0] w_i1_new, w_i2_new;

    function automatic logic signed [W_INT-1:0] sat(input logic signed [W_INT:0] v);
        if (v > LIM_P) return LIM_P[W_INT-1:0];
        if (v < LIM_N) return LIM_N[W_INT-1:0];
        return v[W_INT-1:0];
    endfunction

    // Half-scale input keeps the second-order loop inside its stable range.
    assign w_u      = bus.mute ? '0 : {{(W_INT-14){r_so[15]}}, r_so[15:1]};
    assign w_fb     = r_dac ? FB_P : FB_N;
    assign w_i1_sum = {r_i1[W_INT-1], r_i1} + w_u - w_fb;
    assign w_i1_new = sat(w_i1_sum);
    assign w_i2_sum = {r_i2[W_INT-1], r_i2} + {w_i1_new[W_INT-1], w_i1_new} - w_fb;
    assign w_i2_new = sat(w_i2_sum);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i1    <= '0;
            r_i2    <= '0;
            r_dac   <= 1'b0;
            r_dac_n <= 1'b1;
        end else if (bus.en_sd) begin
            r_i1    <= w_i1_new;
            r_i2    <= w_i2_new;
            r_dac   <= ~w_i2_new[W_INT-1];
            r_dac_n <=  w_i2_new[W_INT-1];
        end
    end

    assign bus.dac   = r_dac;
    assign bus.dac_n = r_dac_n;

endmodule
